uart_tx: RTL and testbench

Serial UART transmitter: accepts a parallel byte through a single-cycle start handshake and shifts it out on `tx`. Frame format is start bit (0), 8 data bits LSB first, an optional even-parity bit, and a stop bit (1). It is the transmit-side counterpart of the team's UART receiver and drives that receiver's `rx` input in loopback benches. One bit time is a fixed number of `clk` cycles; no external baud tick is used.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the transmitter state encoding.
// Used by both uart_tx and the matching receiver.
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_end on the last cycle.
// clear holds the count at zero; shared by the transmitter and receiver.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (11 bit-time frames instead of 10).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            tx_q     <= UART_IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d  = tx_data;
                    idx_d    = '0;
                    state_d  = START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line changes on the same edge as the state.
    always_comb begin
        tx_d   = UART_IDLE_LEVEL;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && bit_end;
        case (state_d)
            START:   tx_d = UART_START_LEVEL;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with CLKS_PER_BIT=4; follows UART_TX_PARITY_EN for frame length.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Issues a one-cycle request; returns at the falling edge just after the accepting edge E.
    task automatic start_frame(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Called at the falling edge after E; checks every bit and the done cycle at E+FB*CPB.
    // inject >= 0 pulses tx_start with 0xFF so that it is sampled at edge E+inject.
    task automatic expect_frame(input logic [7:0] b, input int inject);
        logic [3:0] s;
        logic       busy_ok;
        logic       done_seen;
        busy_ok   = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < FB; k++) begin
            s = '0;
            for (int c = 0; c < CPB; c++) begin
                s[c] = tx;
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (done !== 1'b0) done_seen = 1'b1;
                if (inject >= 0 && (k * CPB + c) == inject - 1) begin
                    tx_start = 1'b1;
                    tx_data  = 8'hFF;
                end
                if (inject >= 0 && (k * CPB + c) == inject) tx_start = 1'b0;
                @(negedge clk);
            end
            check($sformatf("frame_%02h_bit%0d", b, k), 32'(s), 32'({4{frame_bit(b, k)}}));
        end
        check($sformatf("frame_%02h_busy_held", b), 32'(busy_ok), 32'd1);
        check($sformatf("frame_%02h_no_early_done", b), 32'(done_seen), 32'd0);
        check($sformatf("frame_%02h_done_pulse", b), 32'(done), 32'd1);
        check($sformatf("frame_%02h_busy_low_at_done", b), 32'(busy), 32'd0);
        check($sformatf("frame_%02h_tx_idle_at_done", b), 32'(tx), 32'd1);
    endtask

    initial begin
        logic idle_bad;

        rst      = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Idle after reset release
        rst = 1'b1;
        idle_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
        end
        check("idle_100_cycles", 32'(idle_bad), 32'd0);

        // Single frames
        start_frame(8'h55);
        expect_frame(8'h55, -1);
        @(negedge clk);
        check("done_one_cycle_55", 32'(done), 32'd0);

        start_frame(8'h01);
        expect_frame(8'h01, -1);
        @(negedge clk);
        check("done_one_cycle_01", 32'(done), 32'd0);

        // Request during a frame is ignored
        start_frame(8'hA3);
        expect_frame(8'hA3, 12);
        idle_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
        end
        check("ignored_request_no_second_frame", 32'(idle_bad), 32'd0);

        // Back-to-back frames with tx_start held high
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        expect_frame(8'h3C, -1);
        tx_data = 8'hC3;
        @(negedge clk);
        tx_start = 1'b0;
        expect_frame(8'hC3, -1);
        @(negedge clk);
        check("done_one_cycle_C3", 32'(done), 32'd0);
        check("idle_after_b2b", 32'(busy), 32'd0);

        // Asynchronous reset mid-data
        start_frame(8'h00);
        repeat (16) @(negedge clk);
        check("pre_reset_data_low", 32'(tx), 32'd0);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        idle_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
        end
        check("aborted_frame_no_done", 32'(idle_bad), 32'd0);
        start_frame(8'h80);
        expect_frame(8'h80, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
